phi_ladder_generator: RTL and testbench

// Generates the five oscillator drive frequencies (omega_theta..omega_gamma, Q14 omega_dt)

---
 rtl/phi_ladder_generator.sv | 167 ++++++++++++++++
 tb/tb_phi_ladder_generator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phi_ladder_generator.sv
// Phi-spaced five-tone frequency ladder. A single shared multiplier builds the target
// ladder from a base omega, then a slew-limited glide walks the outputs onto it.
module phi_ladder_generator #(
    parameter int WIDTH      = 18,
    parameter int FRAC       = 14,
    parameter int PHI        = 26510,
    parameter int SLEW_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] base_omega,
    input  logic [WIDTH-1:0] detune,
    output logic [WIDTH-1:0] omega_theta,
    output logic [WIDTH-1:0] omega_alpha,
    output logic [WIDTH-1:0] omega_beta1,
    output logic [WIDTH-1:0] omega_beta2,
    output logic [WIDTH-1:0] omega_gamma,
    output logic             targets_valid,
    output logic             settled
);
    localparam int NUM = 5;
    localparam logic signed [2*WIDTH-1:0] SMAX_W = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   SMAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH:0]     PHI_W  = (WIDTH+1)'(PHI);
    localparam logic signed [WIDTH:0]     RMIN   = (WIDTH+1)'(8192);
    localparam logic signed [WIDTH:0]     RMAX   = (WIDTH+1)'(32767);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, GLIDE = 2'd2} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic signed [WIDTH-1:0] ratio_q, ratio_d;
    logic                    sat_q, sat_d;
    logic signed [WIDTH-1:0] sh_q [4];
    logic signed [WIDTH-1:0] sh_d [4];
    logic signed [WIDTH-1:0] tgt_q [NUM];
    logic signed [WIDTH-1:0] tgt_d [NUM];
    logic signed [WIDTH-1:0] out_q [NUM];
    logic signed [WIDTH-1:0] out_d [NUM];
    logic signed [WIDTH-1:0] glide_out [NUM];
    logic                    settled_q, settled_d;
    logic                    tv_q, tv_d;

    logic                      accept;
    logic signed [WIDTH:0]     ratio_sum;
    logic signed [WIDTH-1:0]   ratio_clamped;
    logic signed [WIDTH-1:0]   base_clip;
    logic signed [WIDTH-1:0]   mul_a;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    logic                      term_sat;
    logic signed [WIDTH-1:0]   term;
    logic                      all_match;

    assign accept = cmd_valid && cmd_ready;

    // Shared multiplier: one ladder rung per clock, saturation is sticky for the rest.
    always_comb begin
        ratio_sum     = PHI_W + $signed({detune[WIDTH-1], detune});
        ratio_clamped = (ratio_sum < RMIN) ? RMIN[WIDTH-1:0] :
                        (ratio_sum > RMAX) ? RMAX[WIDTH-1:0] : ratio_sum[WIDTH-1:0];
        base_clip     = base_omega[WIDTH-1] ? '0 : $signed(base_omega);
        mul_a         = sh_q[cnt_q];
        prod          = {{WIDTH{mul_a[WIDTH-1]}}, mul_a} * {{WIDTH{ratio_q[WIDTH-1]}}, ratio_q};
        prod_sh       = prod >>> FRAC;
        term_sat      = sat_q || (prod_sh > SMAX_W);
        term          = term_sat ? SMAX : prod_sh[WIDTH-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_lane
            logic signed [WIDTH:0]   diff;
            logic signed [WIDTH:0]   step_raw;
            logic signed [WIDTH-1:0] step;
            assign diff     = {tgt_q[gi][WIDTH-1], tgt_q[gi]} - {out_q[gi][WIDTH-1], out_q[gi]};
            assign step_raw = diff >>> SLEW_SHIFT;
            // Small residues still creep one LSB toward the target so the glide always lands.
            assign step     = (step_raw != '0) ? step_raw[WIDTH-1:0] :
                              (diff == '0)     ? '0 :
                              diff[WIDTH]      ? '1 : WIDTH'(1);
            assign glide_out[gi] = out_q[gi] + step;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        sat_d     = sat_q;
        sh_d      = sh_q;
        tgt_d     = tgt_q;
        out_d     = out_q;
        tv_d      = 1'b0;
        all_match = 1'b1;
        if (accept) begin
            state_d  = CALC;
            cnt_d    = 2'd0;
            ratio_d  = ratio_clamped;
            sat_d    = 1'b0;
            sh_d[0]  = base_clip;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                CALC: begin
                    sat_d = term_sat;
                    if (cnt_q == 2'd3) begin
                        for (int k = 0; k < 4; k++) tgt_d[k] = sh_q[k];
                        tgt_d[4] = term;
                        tv_d     = 1'b1;
                        state_d  = GLIDE;
                    end else begin
                        sh_d[cnt_q + 2'd1] = term;
                        cnt_d              = cnt_q + 2'd1;
                    end
                end
                GLIDE: if (clk_en) out_d = glide_out;
                default: state_d = IDLE;
            endcase
        end
        for (int k = 0; k < NUM; k++) begin
            if (out_d[k] != tgt_d[k]) all_match = 1'b0;
        end
        if (state_q == GLIDE && !accept && all_match) state_d = IDLE;
        settled_d = all_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            ratio_q   <= '0;
            sat_q     <= 1'b0;
            settled_q <= 1'b1;
            tv_q      <= 1'b0;
            for (int k = 0; k < 4; k++) sh_q[k] <= '0;
            for (int k = 0; k < NUM; k++) begin
                tgt_q[k] <= '0;
                out_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            sat_q     <= sat_d;
            settled_q <= settled_d;
            tv_q      <= tv_d;
            sh_q      <= sh_d;
            tgt_q     <= tgt_d;
            out_q     <= out_d;
        end
    end

    always_comb begin
        cmd_ready     = (state_q != CALC);
        omega_theta   = out_q[0];
        omega_alpha   = out_q[1];
        omega_beta1   = out_q[2];
        omega_beta2   = out_q[3];
        omega_gamma   = out_q[4];
        targets_valid = tv_q;
        settled       = settled_q;
    end
endmodule

// File: tb/tb_phi_ladder_generator.sv
// Bench for phi_ladder_generator: a jump-mode instance checked against a ladder table,
// and a gliding instance checked every clock against an arithmetic reference model.
module tb_phi_ladder_generator;
    localparam int SHIFT = 3;
    localparam int SMAXI = 131071;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, cmd_valid;
    logic [17:0] base_omega, detune;
    logic        ready0, tv0, st0, ready3, tv3, st3;
    logic [17:0] w0 [5];
    logic [17:0] w3 [5];

    always #5 clk = ~clk;

    phi_ladder_generator #(.SLEW_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cmd_valid(cmd_valid), .cmd_ready(ready0),
        .base_omega(base_omega), .detune(detune),
        .omega_theta(w0[0]), .omega_alpha(w0[1]), .omega_beta1(w0[2]), .omega_beta2(w0[3]),
        .omega_gamma(w0[4]), .targets_valid(tv0), .settled(st0)
    );

    phi_ladder_generator #(.SLEW_SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cmd_valid(cmd_valid), .cmd_ready(ready3),
        .base_omega(base_omega), .detune(detune),
        .omega_theta(w3[0]), .omega_alpha(w3[1]), .omega_beta1(w3[2]), .omega_beta2(w3[3]),
        .omega_gamma(w3[4]), .targets_valid(tv3), .settled(st3)
    );

    int checks = 0;
    int errors = 0;
    int m_out [5];
    int m_tgt [5];
    int m_pend [5];
    bit m_busy;
    int m_commit;
    int cyc = 0;

    typedef struct {
        int base;
        int det;
        int e [5];
    } vec_t;
    vec_t vecs [9];

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference ladder: ratio = phi + detune clamped, each rung = floor(prev * ratio / 2^14).
    function automatic void calc_ladder(int base, int det);
        longint r, v;
        bit sat;
        r = 26510 + det;
        if (r < 8192) r = 8192;
        if (r > 32767) r = 32767;
        v = (base > 0) ? base : 0;
        m_pend[0] = int'(v);
        sat = 0;
        for (int k = 1; k < 5; k++) begin
            v = (v * r) / 16384;
            if (sat || v > SMAXI) begin
                sat = 1;
                v = SMAXI;
            end
            m_pend[k] = int'(v);
        end
    endfunction

    function automatic void glide_step();
        for (int k = 0; k < 5; k++) begin
            int d, s;
            d = m_tgt[k] - m_out[k];
            s = (d >= 0) ? d / (1 << SHIFT) : -((-d + (1 << SHIFT) - 1) / (1 << SHIFT));
            if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
            m_out[k] += s;
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 5; k++) begin
            m_out[k] = 0;
            m_tgt[k] = 0;
        end
        m_busy = 0;
    endfunction

    function automatic void set_vec(int i, int b, int d, int e0, int e1, int e2, int e3, int e4);
        vecs[i].base = b;
        vecs[i].det  = d;
        vecs[i].e[0] = e0;
        vecs[i].e[1] = e1;
        vecs[i].e[2] = e2;
        vecs[i].e[3] = e3;
        vecs[i].e[4] = e4;
    endfunction

    // One clock: advance the model from the pre-edge inputs, then compare the gliding DUT.
    task automatic tick();
        bit acc, busy_pre, en, tv_exp, all_eq;
        int b, dt;
        busy_pre = m_busy;
        acc      = (cmd_valid === 1'b1) && !m_busy;
        en       = (clk_en === 1'b1);
        b        = int'($signed(base_omega));
        dt       = int'($signed(detune));
        @(posedge clk);
        #1;
        cyc++;
        tv_exp = 0;
        if (busy_pre) begin
            if (cyc == m_commit) begin
                m_tgt  = m_pend;
                m_busy = 0;
                tv_exp = 1;
            end
        end else if (acc) begin
            calc_ladder(b, dt);
            m_busy   = 1;
            m_commit = cyc + 4;
        end else if (en) begin
            glide_step();
        end
        all_eq = 1;
        for (int k = 0; k < 5; k++) if (m_out[k] != m_tgt[k]) all_eq = 0;
        for (int k = 0; k < 5; k++) chk($sformatf("model_omega%0d", k), int'(w3[k]), m_out[k]);
        chk("model_cmd_ready", int'(ready3), int'(!m_busy));
        chk("model_targets_valid", int'(tv3), int'(tv_exp));
        chk("model_settled", int'(st3), int'(all_eq));
    endtask

    function automatic void check_reset_state(string tag);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("%s_omega%0d", tag, k), int'(w3[k]), 0);
            chk($sformatf("%s_j_omega%0d", tag, k), int'(w0[k]), 0);
        end
        chk({tag, "_cmd_ready"}, int'(ready3), 1);
        chk({tag, "_settled"}, int'(st3), 1);
        chk({tag, "_targets_valid"}, int'(tv3), 0);
    endfunction

    // Asserted between edges: outputs must clear with no clock edge.
    task automatic async_reset(string tag);
        #2;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_reset_state(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk({tag, "_post_ready"}, int'(ready3), 1);
        chk({tag, "_post_settled"}, int'(st3), 1);
    endtask

    initial begin
        int prev [5];
        int frozen [5];
        int seq [3];
        int n;
        bit same;

        seq[0] = 12; seq[1] = 23; seq[2] = 32;
        set_vec(0, 100, 0, 100, 161, 260, 420, 679);
        set_vec(1, 100, -10126, 100, 100, 100, 100, 100);
        set_vec(2, 20000, 0, 20000, 32360, 52359, 84719, 131071);
        set_vec(3, -5, 0, 0, 0, 0, 0, 0);
        set_vec(4, 100, 20000, 100, 199, 397, 793, 1585);
        set_vec(5, 100, -20000, 100, 50, 25, 12, 6);
        set_vec(6, 70000, 0, 70000, 113262, 131071, 131071, 131071);
        set_vec(7, 70000, 0, 70000, 113262, 131071, 131071, 131071);
        set_vec(8, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0; clk_en = 1'b0; cmd_valid = 1'b0; base_omega = '0; detune = '0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ladder table on the jump-mode instance.
        for (int k = 0; k < 5; k++) prev[k] = 0;
        for (int i = 0; i < 9; i++) begin
            int b, d;
            b = vecs[i].base;
            d = vecs[i].det;
            same = 1;
            for (int k = 0; k < 5; k++) if (prev[k] != vecs[i].e[k]) same = 0;
            $display("vec %0d: base=%0d detune=%0d -> %0d %0d %0d %0d %0d", i, b, d,
                     vecs[i].e[0], vecs[i].e[1], vecs[i].e[2], vecs[i].e[3], vecs[i].e[4]);
            base_omega = b[17:0];
            detune     = d[17:0];
            clk_en     = 1'b0;
            chk($sformatf("vec%0d_ready_before", i), int'(ready0), 1);
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                chk($sformatf("vec%0d_calc_ready", i), int'(ready0), 0);
                tick();
                chk($sformatf("vec%0d_calc_tv", i), int'(tv0), 0);
                chk($sformatf("vec%0d_calc_hold", i), int'(w0[0]), prev[0]);
            end
            tick();
            chk($sformatf("vec%0d_tv", i), int'(tv0), 1);
            chk($sformatf("vec%0d_commit_hold", i), int'(w0[4]), prev[4]);
            chk($sformatf("vec%0d_commit_settled", i), int'(st0), int'(same));
            clk_en = 1'b1;
            tick();
            clk_en = 1'b0;
            for (int k = 0; k < 5; k++)
                chk($sformatf("vec%0d_omega%0d", i, k), int'(w0[k]), vecs[i].e[k]);
            chk($sformatf("vec%0d_settled", i), int'(st0), 1);
            chk($sformatf("vec%0d_tv_pulse", i), int'(tv0), 0);
            tick();
            chk($sformatf("vec%0d_idle_ready", i), int'(ready0), 1);
            for (int k = 0; k < 5; k++) prev[k] = vecs[i].e[k];
        end

        // Glide from reset: theta trajectory, monotonic rise, settle within 64 ticks.
        async_reset("pre_glide");
        base_omega = 18'd100;
        detune     = '0;
        clk_en     = 1'b1;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 5; k++) prev[k] = int'(w3[k]);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("theta_seq%0d", s), int'(w3[0]), seq[s]);
        end
        n = 3;
        for (int k = 0; k < 5; k++) prev[k] = int'(w3[k]);
        while (st3 !== 1'b1 && n < 64) begin
            tick();
            n++;
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("mono%0d", k), int'(int'(w3[k]) >= prev[k]), 1);
                chk($sformatf("no_overshoot%0d", k), int'(int'(w3[k]) <= m_tgt[k]), 1);
                prev[k] = int'(w3[k]);
            end
        end
        chk("settle_within_64", int'(st3), 1);
        chk("settled_gamma", int'(w3[4]), 679);

        // Second command mid-glide: accepted, outputs frozen through CALC.
        base_omega = 18'd1000;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        chk("midglide_ready", int'(ready3), 1);
        chk("midglide_moving", int'(st3), 0);
        base_omega = 18'd200;
        cmd_valid  = 1'b1;
        for (int k = 0; k < 5; k++) frozen[k] = int'(w3[k]);
        tick();
        chk("accept_hold", int'(w3[0]), frozen[0]);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("calc_ready_low%0d", c), int'(ready3), 0);
            tick();
            for (int k = 0; k < 5; k++)
                chk($sformatf("calc_frozen%0d_%0d", c, k), int'(w3[k]), frozen[k]);
        end
        cmd_valid = 1'b0;
        n = 0;
        tick();
        while (st3 !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("second_settled", int'(st3), 1);
        chk("second_theta", int'(w3[0]), 200);

        // Reset during CALC, then during GLIDE.
        base_omega = 18'd5000;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        async_reset("mid_calc");
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        async_reset("mid_glide");

        // Randomized commands, detunes and update strobes.
        for (int i = 0; i < 500; i++) begin
            int b, d;
            if (i == 250) async_reset("rand_reset");
            b = ($urandom_range(0, 9) == 0) ? -int'($urandom_range(1, 5000))
                                            : int'($urandom_range(0, SMAXI));
            d = int'($urandom_range(0, 30000)) - 20000;
            base_omega = b[17:0];
            detune     = d[17:0];
            cmd_valid  = ($urandom_range(0, 15) == 0);
            clk_en     = ($urandom_range(0, 1) == 1);
            tick();
        end
        cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
